// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 4-bit control encoding produced by the ALU decoder
// and the execute-stage FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ALU_STATE_t;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SRL) || (ctrl == ALU_SRA) || (ctrl == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational single-cycle ALU ops plus detection of unencoded controls.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             slt_s;
  logic             sltu_s;

  assign sum_s  = a + b;
  assign diff_s = a - b;
  assign slt_s  = $signed(a) < $signed(b);
  assign sltu_s = a < b;

  // op select; shift codes pass A through so a zero-amount shift finishes here
  always_comb begin
    result  = {WIDTH{1'b0}};
    illegal = 1'b0;
    case (ctrl)
      ALU_ADD:  result = sum_s;
      ALU_SUB:  result = diff_s;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_s};
      ALU_SRL, ALU_SRA, ALU_SLL: result = a;
      default: begin
        result  = {WIDTH{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops through alu_core, a 1-bit-per-cycle serial
// shifter, valid/ready handshake on both sides and a synchronous flush.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  input  logic             flush,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal_o
);

  ALU_STATE_t         state_r, next_state_s;
  logic [WIDTH-1:0]   w_r, shifted_s, core_result_s, result_r;
  logic [SHAMT_W-1:0] cnt_r, shamt_s;
  logic [3:0]         kind_r;
  logic               core_illegal_s, accept_s, start_shift_s, shift_last_s;
  logic               zero_r, illegal_r, valid_r;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a       (SrcA),
    .b       (SrcB),
    .ctrl    (ALUControl),
    .result  (core_result_s),
    .illegal (core_illegal_s)
  );

  assign shamt_s       = SrcB[SHAMT_W-1:0];
  assign accept_s      = valid_i & ready_o & ~flush;
  assign start_shift_s = accept_s & is_shift(ALUControl) & (shamt_s != {SHAMT_W{1'b0}});
  assign shift_last_s  = (state_r == SHIFT) & (cnt_r == SHAMT_W'(1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= next_state_s;
  end

  // next state; flush overrides any handshake
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) next_state_s = start_shift_s ? SHIFT : DONE;
          else          next_state_s = IDLE;
        end
        SHIFT: next_state_s = (cnt_r == SHAMT_W'(1)) ? DONE : SHIFT;
        DONE: begin
          if (accept_s)     next_state_s = start_shift_s ? SHIFT : DONE;
          else if (ready_i) next_state_s = IDLE;
          else              next_state_s = DONE;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // upstream ready depends only on state and downstream ready
  always_comb begin
    ready_o = 1'b0;
    case (state_r)
      IDLE:    ready_o = 1'b1;
      DONE:    ready_o = ready_i;
      default: ready_o = 1'b0;
    endcase
  end

  // one step of the serial shifter
  always_comb begin
    shifted_s = w_r;
    case (kind_r)
      ALU_SRL: shifted_s = {1'b0, w_r[WIDTH-1:1]};
      ALU_SRA: shifted_s = {w_r[WIDTH-1], w_r[WIDTH-1:1]};
      ALU_SLL: shifted_s = {w_r[WIDTH-2:0], 1'b0};
      default: shifted_s = w_r;
    endcase
  end

  // datapath and result registers; a flushed cycle leaves the old result in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_r       <= {WIDTH{1'b0}};
      cnt_r     <= {SHAMT_W{1'b0}};
      kind_r    <= 4'b0000;
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
      valid_r   <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (start_shift_s) begin
      w_r     <= SrcA;
      cnt_r   <= shamt_s;
      kind_r  <= ALUControl;
      valid_r <= 1'b0;
    end else if (accept_s) begin
      result_r  <= core_result_s;
      zero_r    <= (core_result_s == {WIDTH{1'b0}});
      illegal_r <= core_illegal_s;
      valid_r   <= 1'b1;
    end else if (state_r == SHIFT) begin
      w_r   <= shifted_s;
      cnt_r <= cnt_r - SHAMT_W'(1);
      if (shift_last_s) begin
        result_r  <= shifted_s;
        zero_r    <= (shifted_s == {WIDTH{1'b0}});
        illegal_r <= 1'b0;
        valid_r   <= 1'b1;
      end
    end else if (ready_i) begin
      valid_r <= 1'b0;
    end
  end

  assign valid_o   = valid_r;
  assign ALUResult = result_r;
  assign Zero      = zero_r;
  assign illegal_o = illegal_r;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: table of ops checked through a scoreboard, plus hand-written
// backpressure, flush and reset-mid-shift sequences.
module tb_alu_exec;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic             clk = 1'b0;
  logic             reset_n, valid_i, ready_o, flush, valid_o, ready_i, Zero, illegal_o;
  logic [WIDTH-1:0] SrcA, SrcB, ALUResult;
  logic [3:0]       ALUControl;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .flush(flush),
    .valid_o(valid_o), .ready_i(ready_i), .ALUResult(ALUResult),
    .Zero(Zero), .illegal_o(illegal_o)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    check({name, "_pending"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, "_res"}, ALUResult, e.res);
      check1({name, "_zero"}, Zero, e.zero);
      check1({name, "_ill"}, illegal_o, e.ill);
    end
  endtask

  // called at a falling edge; returns at the falling edge after the accepting edge
  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    valid_i    = 1'b1;
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   seen;

    vecs.push_back('{4'h0, 32'd5,          32'd7,          32'd12,         1'b0, 1});
    vecs.push_back('{4'h1, 32'd5,          32'd5,          32'd0,          1'b0, 1});
    vecs.push_back('{4'h5, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1});
    vecs.push_back('{4'h9, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1});
    vecs.push_back('{4'h0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1});
    vecs.push_back('{4'h1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1});
    vecs.push_back('{4'h2, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1});
    vecs.push_back('{4'h3, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  1'b0, 1});
    vecs.push_back('{4'h4, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  32'h5555_5555,  1'b0, 1});
    vecs.push_back('{4'h5, 32'd5,          32'hFFFF_FFFF,  32'd0,          1'b0, 1});
    vecs.push_back('{4'h8, 32'd1,          32'd4,          32'h0000_0010,  1'b0, 5});
    vecs.push_back('{4'h7, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  1'b0, 32});
    vecs.push_back('{4'h6, 32'h8000_0000,  32'd31,         32'd1,          1'b0, 32});
    vecs.push_back('{4'h8, 32'd1,          32'h0000_0020,  32'd1,          1'b0, 1});
    vecs.push_back('{4'h7, 32'h8000_00F0,  32'd4,          32'hF800_000F,  1'b0, 5});
    vecs.push_back('{4'h6, 32'hF000_0000,  32'h0000_0023,  32'h1E00_0000,  1'b0, 4});
    vecs.push_back('{4'hF, 32'hDEAD_BEEF,  32'd1,          32'd0,          1'b1, 1});
    vecs.push_back('{4'hA, 32'd5,          32'd7,          32'd0,          1'b1, 1});
    vecs.push_back('{4'h9, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 1});

    reset_n = 1'b0; valid_i = 1'b0; flush = 1'b0; ready_i = 1'b1;
    SrcA = 32'd0; SrcB = 32'd0; ALUControl = 4'h0;
    repeat (2) @(negedge clk);
    check1("rst_valid", valid_o, 1'b0);
    check("rst_result", ALUResult, 32'd0);
    check1("rst_zero", Zero, 1'b0);
    check1("rst_ill", illegal_o, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check1("rst_ready", ready_o, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      check1($sformatf("v%0d_ready", i), ready_o, 1'b1);
      sb_q.push_back('{v.res, (v.res == 32'd0), v.ill});
      issue(v.ctrl, v.a, v.b);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
      sb_check($sformatf("v%0d", i));
      @(negedge clk);
    end

    // backpressure then back-to-back accept
    ready_i = 1'b0;
    sb_q.push_back('{32'd30, 1'b0, 1'b0});
    issue(4'h0, 32'd10, 32'd20);
    check1("bp_valid", valid_o, 1'b1);
    sb_check("bp_first");
    valid_i = 1'b1; ALUControl = 4'h1; SrcA = 32'd1; SrcB = 32'd1;
    for (int k = 0; k < 3; k++) begin
      check1($sformatf("bp_ready_%0d", k), ready_o, 1'b0);
      @(negedge clk);
      check($sformatf("bp_hold_res_%0d", k), ALUResult, 32'd30);
      check1($sformatf("bp_hold_valid_%0d", k), valid_o, 1'b1);
    end
    ALUControl = 4'h0; SrcA = 32'd100; SrcB = 32'd23; ready_i = 1'b1;
    sb_q.push_back('{32'd123, 1'b0, 1'b0});
    #1;
    check1("b2b_ready", ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    check1("b2b_valid", valid_o, 1'b1);
    sb_check("b2b");
    @(negedge clk);

    // flush mid-shift, with a valid op presented in the flush cycle
    issue(4'h8, 32'd1, 32'd10);
    @(negedge clk);
    flush = 1'b1; valid_i = 1'b1; ALUControl = 4'h0; SrcA = 32'd2; SrcB = 32'd2;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; valid_i = 1'b0;
    check1("flush_ready", ready_o, 1'b1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    check("flush_keep_res", ALUResult, 32'd123);

    // flush in IDLE drops a simultaneous handshake
    flush = 1'b1; valid_i = 1'b1; ALUControl = 4'h0; SrcA = 32'd2; SrcB = 32'd2;
    #1;
    check1("flush_idle_ready", ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; valid_i = 1'b0;
    check1("flush_idle_valid", valid_o, 1'b0);
    @(negedge clk);
    check1("flush_idle_valid2", valid_o, 1'b0);
    check("flush_idle_res", ALUResult, 32'd123);

    // asynchronous reset in the middle of a shift
    issue(4'h7, 32'h8000_0000, 32'd20);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstmid_res", ALUResult, 32'd0);
    check1("rstmid_valid", valid_o, 1'b0);
    check1("rstmid_zero", Zero, 1'b0);
    check1("rstmid_ill", illegal_o, 1'b0);
    check1("rstmid_ready", ready_o, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    check("rstmid_no_valid", 32'(seen), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
